// File: rtl/sarray_mem_resp.sv
// sarray_mem_resp: single-port word memory with a K-beat write FSM and an OST-deep,
// in-order read response FIFO. Optional address bounds check: SARRAY_MEM_BOUND_CHK_EN.
module sarray_mem_resp #(
  parameter int ADDR_W  = 64,
  parameter int LOAD_W  = 256,
  parameter int STORE_W = 512,
  parameter int DEPTH   = 256,
  parameter int OST     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ar_valid_i,
  output logic               ar_ready_o,
  input  logic [ADDR_W-1:0]  ar_addr_i,
  output logic               r_valid_o,
  input  logic               r_ready_i,
  output logic [LOAD_W-1:0]  r_data_o,
  input  logic               aw_valid_i,
  output logic               aw_ready_o,
  input  logic [ADDR_W-1:0]  aw_addr_i,
  input  logic [STORE_W-1:0] aw_data_i
`ifdef SARRAY_MEM_BOUND_CHK_EN
  ,
  output logic               err_o
`endif
);

  localparam int K      = STORE_W / LOAD_W;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BEAT_W = (K > 1) ? $clog2(K) : 1;
  localparam int PTR_W  = (OST > 1) ? $clog2(OST) : 1;
  localparam int CNT_W  = $clog2(OST + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, WR = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   wr_base, wr_base_nxt;
  logic [BEAT_W-1:0]  beat, beat_nxt;
  logic [STORE_W-1:0] wr_data, wr_data_nxt;
  logic               wr_oob, wr_oob_nxt;

  logic               mem_we;
  logic [IDX_W-1:0]   mem_widx;
  logic [LOAD_W-1:0]  mem_wdata;
  logic [LOAD_W-1:0]  mem [DEPTH];
  logic [LOAD_W-1:0]  rd_word;
  logic               rd_pend;
  logic               rd_oob;

  logic [LOAD_W-1:0]  fifo_data [OST];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt, inflight;

  logic               aw_fire, ar_fire, r_fire;
  logic               ar_oob, aw_oob;
  logic [IDX_W-1:0]   ar_idx, aw_idx;
  logic               unused_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OST - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Only bits [8 +: IDX_W] select a word; the byte offset within a 256-byte beat is ignored.
  assign ar_idx      = ar_addr_i[8 +: IDX_W];
  assign aw_idx      = aw_addr_i[8 +: IDX_W];
  assign unused_addr = ^{ar_addr_i, aw_addr_i};

`ifdef SARRAY_MEM_BOUND_CHK_EN
  assign ar_oob = |ar_addr_i[ADDR_W-1:8+IDX_W];
  assign aw_oob = |aw_addr_i[ADDR_W-1:8+IDX_W];
`else
  assign ar_oob = 1'b0;
  assign aw_oob = 1'b0;
`endif

  // Writes take priority over reads, and reads are held off while a multi-beat write drains.
  assign aw_ready_o = ~rst & (state == IDLE);
  assign ar_ready_o = ~rst & (state == IDLE) & ~aw_valid_i & (inflight < CNT_W'(OST));
  assign aw_fire    = aw_valid_i & aw_ready_o;
  assign ar_fire    = ar_valid_i & ar_ready_o;

  // Write FSM next-state and memory write port selection
  always_comb begin
    state_nxt   = state;
    wr_base_nxt = wr_base;
    beat_nxt    = beat;
    wr_data_nxt = wr_data;
    wr_oob_nxt  = wr_oob;
    mem_we      = 1'b0;
    mem_widx    = aw_idx;
    mem_wdata   = aw_data_i[LOAD_W-1:0];
    case (state)
      IDLE: begin
        if (aw_fire) begin
          mem_we      = ~aw_oob;
          wr_base_nxt = aw_idx;
          wr_data_nxt = aw_data_i;
          wr_oob_nxt  = aw_oob;
          beat_nxt    = BEAT_W'(1);
          if (K > 1) begin
            state_nxt = WR;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WR: begin
        mem_we    = ~wr_oob;
        mem_widx  = wr_base + IDX_W'(beat);
        mem_wdata = wr_data[beat*LOAD_W +: LOAD_W];
        beat_nxt  = beat + BEAT_W'(1);
        if (beat == BEAT_W'(K - 1)) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WR;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Write FSM state and captured write payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_base <= '0;
      beat    <= '0;
      wr_data <= '0;
      wr_oob  <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_base <= wr_base_nxt;
      beat    <= beat_nxt;
      wr_data <= wr_data_nxt;
      wr_oob  <= wr_oob_nxt;
    end
  end

  // Single-port array: one write or one read per cycle, never reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end else if (ar_fire) begin
      rd_word <= mem[ar_idx];
    end
  end

  // Read pipeline stage between the array and the response FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_oob  <= 1'b0;
    end else begin
      rd_pend <= ar_fire;
      rd_oob  <= ar_fire & ar_oob;
    end
  end

  assign r_valid_o = (fifo_cnt != '0);
  assign r_data_o  = fifo_data[rd_ptr];
  assign r_fire    = r_valid_o & r_ready_i;

  // Response FIFO storage; out-of-range beats are stored as zero
  always_ff @(posedge clk) begin
    if (rd_pend) begin
      fifo_data[wr_ptr] <= rd_oob ? '0 : rd_word;
    end
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (rd_pend) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (r_fire) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({rd_pend, r_fire})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Outstanding reads, counted from acceptance until the beat is consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({ar_fire, r_fire})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

`ifdef SARRAY_MEM_BOUND_CHK_EN
  logic [OST-1:0] fifo_oob;

  // Per-entry out-of-range flag travelling alongside the response data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_oob <= '0;
    end else if (rd_pend) begin
      fifo_oob[wr_ptr] <= rd_oob;
    end else begin
      fifo_oob <= fifo_oob;
    end
  end

  assign err_o = (r_fire & fifo_oob[rd_ptr]) | (aw_fire & aw_oob);
`endif

endmodule

// File: doc/sarray_mem_resp.md
SARRAY_MEM_RESP -- requirements
Module: sarray_mem_resp

Interface
REQ-001 Parameter ADDR_W, default 64: address width of ar/aw channels.
REQ-002 Parameter LOAD_W, default 256: read beat width; equals one memory word.
REQ-003 Parameter STORE_W, default 512: write beat width; SHALL be K·LOAD_W, K≥1 integer.
REQ-004 Parameter DEPTH, default 256: memory words, power of two.
REQ-005 Parameter OST, default 4: maximum reads accepted but not yet returned.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 ar_valid_i  in  1  read request valid.
REQ-009 ar_ready_o  out  1  read request accepted.
REQ-010 ar_addr_i  in  ADDR_W  read byte address.
REQ-011 r_valid_o  out  1  read data valid.
REQ-012 r_ready_i  in  1  read data consumed.
REQ-013 r_data_o  out  LOAD_W  read data.
REQ-014 aw_valid_i  in  1  write request valid.
REQ-015 aw_ready_o  out  1  write request accepted.
REQ-016 aw_addr_i  in  ADDR_W  write byte address.
REQ-017 aw_data_i  in  STORE_W  write data; word j = bits [j·LOAD_W +: LOAD_W].
REQ-018 err_o  out  1  out-of-range pulse; present only with SARRAY_MEM_BOUND_CHK_EN.

Function
REQ-019 Word index = addr[8 +: log2(DEPTH)]; address bits [7:0] ignored (256-byte beat stride).
REQ-020 Handshake on a channel = valid & ready in the same cycle; a valid, once raised, is held with stable payload until its handshake.
REQ-021 Memory is single-port: at most one word read or written per cycle.
REQ-022 Write FSM states: IDLE, WR. aw_ready_o = (state==IDLE).
REQ-023 aw handshake in IDLE writes word 0 to index i in that cycle; K=1 stays IDLE, K>1 goes to WR.
REQ-024 In WR, word j writes to index (i+j) mod DEPTH on successive cycles; after word K-1 returns to IDLE.
REQ-025 ar_ready_o = (state==IDLE) & ~aw_valid_i & (inflight < OST); aw wins simultaneous ar/aw.
REQ-026 Memory read issues in the ar-handshake cycle T; data enters an OST-entry response FIFO at T+1; r_valid_o first high at T+2.
REQ-027 r_valid_o = FIFO non-empty; r_data_o = FIFO head; FIFO pops on r handshake.
REQ-028 inflight counter: +1 on ar handshake, −1 on r handshake, unchanged on both; never exceeds OST, so the FIFO never overflows.
REQ-029 Read data returns in ar acceptance order; a read accepted after a write's last word sees the written data.
REQ-030 Sustained throughput: one read beat per cycle when r_ready_i=1 and no writes pending.
REQ-031 r_valid_o held and r_data_o stable while r_ready_i=0.

Reset
REQ-032 On rst: state=IDLE, inflight=0, FIFO empty; r_valid_o=0, err_o=0.
REQ-033 While rst is asserted: ar_ready_o=0, aw_ready_o=0.
REQ-034 Reset mid-operation discards in-flight reads and unfinished write beats; memory array is not reset, and completed writes are retained.

Configuration
REQ-035 Macro SARRAY_MEM_BOUND_CHK_EN defined: an address with any bit above index range set is out of range.
REQ-036 Out-of-range read: returns all-zero data in normal order and pulses err_o for one cycle with that beat's r handshake.
REQ-037 Out-of-range write: handshake completes with normal timing, memory unmodified, err_o pulses in the aw-handshake cycle.
REQ-038 Macro undefined: upper address bits are ignored (index wraps), and err_o does not exist.

Verification
REQ-039 aw addr 0x0, data {W1,W0}; then ar 0x0, ar 0x100 -> r returns W0, then W1; first r_valid_o 2 cycles after first ar handshake.
REQ-040 r_ready_i=0 with 6 back-to-back ars -> exactly 4 accepted, ar_ready_o low; r_ready_i=1 -> 4 beats in order, then remaining 2 accepted.
REQ-041 ar_valid_i and aw_valid_i raised the same cycle, same address -> aw accepted first; ar accepted after FSM returns to IDLE; r returns the new data.
REQ-042 aw at word index DEPTH−1 with K=2 -> word 1 written to index 0 (wrap-around).
REQ-043 rst pulsed while FSM in WR with 2 reads in flight -> next cycle r_valid_o=0, aw_ready_o=1, word 0 retained, no stale r beats.
REQ-044 With SARRAY_MEM_BOUND_CHK_EN, ar to 0x10000 (DEPTH=256) -> zero data, err_o=1 for one cycle; without the macro, data of index 0 is returned.
